block_collector: RTL and testbench

Stream-to-block deserializer for the JPEG datapath: accepts one 8-bit sample per clock under a valid/ready handshake and assembles 64 consecutive samples into one 8×8 block presented as a 64-entry parallel word. It is the receive-side counterpart of the block-to-byte serializer. It sits between the byte-stream source (input interface / entropy decoder output) and the block-parallel stages (DCT/IDCT, quantizer). Two ping-pong banks let a new block stream in while the previous one waits for the consumer.

---
 rtl/jpeg_blk_pkg.sv | 23 ++
 rtl/blk_bank.sv | 62 ++++++
 rtl/block_collector.sv | 105 ++++++++++
 tb/tb_block_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_blk_pkg.sv
// Shared types for the 8x8 block datapath: sample/block types and ping-pong bank states.
// Also holds the framing-error rule so the bank writer and anyone else agree on it.
package jpeg_blk_pkg;

   localparam int BYTE_W = 8;
   localparam int BLK_N  = 64;
   localparam int IDX_W  = $clog2(BLK_N);

   typedef logic [BYTE_W-1:0] byte_t;
   typedef byte_t blk_t [0:BLK_N-1];

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_t;

   // A block is well framed only when in_last lands exactly on the final slot.
   function automatic logic frame_err(input logic last, input logic [IDX_W-1:0] idx);
      return last ^ (idx == IDX_W'(BLK_N - 1));
   endfunction

endpackage

// File: rtl/blk_bank.sv
// One ping-pong bank: 64-sample storage, EMPTY/FILLING/FULL state and framing-error bit.
// Writes land on the next edge; a clear empties the bank and zeroes its contents in one cycle.
module blk_bank
   import jpeg_blk_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [BYTE_W-1:0] data,
   input  logic             done,
   input  logic             err_in,
   input  logic             clr,
   output bank_state_t      state,
   output logic             err,
   output logic [BYTE_W-1:0] mem [0:BLK_N-1]
);

   bank_state_t state_q, state_d;
   logic        err_q, err_d;
   blk_t        mem_q, mem_d;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      mem_d   = mem_q;
      if (clr) begin
         state_d = EMPTY;
         err_d   = 1'b0;
         for (int i = 0; i < BLK_N; i++) begin
            mem_d[i] = '0;
         end
      end else if (we) begin
         mem_d[idx] = data;
         if (done) begin
            state_d = FULL;
            err_d   = err_in;
         end else begin
            state_d = FILLING;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         err_q   <= 1'b0;
         for (int i = 0; i < BLK_N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

   assign state = state_q;
   assign err   = err_q;
   assign mem   = mem_q;

endmodule

// File: rtl/block_collector.sv
// Sample stream to 8x8 block deserializer with two ping-pong banks; block valid the cycle after its last sample.
// in_ready drops only while the write bank is still FULL; y/out_err come straight from the read bank's storage.
module block_collector
   import jpeg_blk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] y [0:BLK_N-1],
   output logic              out_err
);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;

   bank_state_t      st0, st1;
   logic             err0, err1;
   logic [BYTE_W-1:0] mem0 [0:BLK_N-1];
   logic [BYTE_W-1:0] mem1 [0:BLK_N-1];

   logic accept, done, release_blk, err_in;
   logic we0, we1, clr0, clr1;

   always_comb begin
      in_ready    = wr_bank_q ? (st1 != FULL) : (st0 != FULL);
      out_valid   = rd_bank_q ? (st1 == FULL) : (st0 == FULL);
      out_err     = rd_bank_q ? err1 : err0;
      accept      = in_valid && in_ready;
      done        = accept && (in_last || (idx_q == IDX_W'(BLK_N - 1)));
      release_blk = out_valid && out_ready;
      err_in      = frame_err(in_last, idx_q);

      idx_d     = idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (accept) begin
         idx_d = done ? '0 : idx_q + IDX_W'(1);
      end
      if (done) begin
         wr_bank_d = ~wr_bank_q;
      end
      if (release_blk) begin
         rd_bank_d = ~rd_bank_q;
      end

      // Write and clear never target the same bank: a FULL write bank blocks input.
      we0  = accept && !wr_bank_q;
      we1  = accept && wr_bank_q;
      clr0 = release_blk && !rd_bank_q;
      clr1 = release_blk && rd_bank_q;
   end

   always_comb begin
      for (int i = 0; i < BLK_N; i++) begin
         y[i] = rd_bank_q ? mem1[i] : mem0[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   blk_bank u_bank0 (
      .clk    (clk),
      .rst    (rst),
      .we     (we0),
      .idx    (idx_q),
      .data   (in_data),
      .done   (done),
      .err_in (err_in),
      .clr    (clr0),
      .state  (st0),
      .err    (err0),
      .mem    (mem0)
   );

   blk_bank u_bank1 (
      .clk    (clk),
      .rst    (rst),
      .we     (we1),
      .idx    (idx_q),
      .data   (in_data),
      .done   (done),
      .err_in (err_in),
      .clr    (clr1),
      .state  (st1),
      .err    (err1),
      .mem    (mem1)
   );

endmodule

// File: tb/tb_block_collector.sv
// Directed table plus scoreboarded stream scenarios for block_collector.
module tb_block_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] y [0:63];
   logic       out_err;

   block_collector dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   int n_blk = 0;
   int m_blocks = 0;

   // Drive control: pmode 0 idle, 1 table row, 2 queue; cmode 0 off, 1 manual ready, 2 random ready.
   int          pmode = 0;
   int          cmode = 0;
   int unsigned p_rate = 100;
   int unsigned c_rate = 100;
   logic        t_iv = 1'b0;
   logic [7:0]  t_d = 8'h00;
   logic        t_l = 1'b0;
   logic        man_ready = 1'b0;

   logic [7:0]   src_d [$];
   logic         src_l [$];
   logic [511:0] exp_y [$];
   logic         exp_e [$];
   logic [7:0]   m_buf [64];
   int           m_cnt = 0;

   typedef struct packed {
      logic       iv;
      logic [7:0] d;
      logic       l;
      logic       ordy;
      logic       e_rdy;
      logic       e_ov;
      logic       e_err;
      logic [5:0] yi;
      logic [7:0] yv;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic l, input logic ordy,
                               input logic e_rdy, input logic e_ov, input logic e_err,
                               input logic [5:0] yi, input logic [7:0] yv);
      vec_t v;
      v.iv = iv; v.d = d; v.l = l; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_err = e_err; v.yi = yi; v.yv = yv;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (row %0d): got %h, want %h", nm, row, act, exp);
      end
   endtask

   // Reference framing: complete on in_last or on the 64th sample, pad with zeros.
   task automatic mpush(input logic [7:0] d, input logic l);
      logic [511:0] e;
      src_d.push_back(d);
      src_l.push_back(l);
      m_buf[m_cnt] = d;
      m_cnt++;
      if (l || m_cnt == 64) begin
         e = '0;
         for (int i = 0; i < m_cnt; i++) e[i*8 +: 8] = m_buf[i];
         exp_y.push_back(e);
         exp_e.push_back(!(l && m_cnt == 64));
         m_cnt = 0;
         m_blocks++;
      end
   endtask

   task automatic drain(input string nm, input int budget);
      int c;
      c = 0;
      while ((src_d.size() != 0 || in_valid || exp_y.size() != 0) && c < budget) begin
         @(posedge clk); #2;
         c++;
      end
      n_vec++;
      if (c >= budget) begin
         n_err++;
         $display("FAIL %s drain timeout: %0d samples, %0d blocks left", nm, src_d.size(), exp_y.size());
      end
   endtask

   initial begin : producer
      logic take;
      take = 1'b0;
      forever begin
         @(negedge clk);
         case (pmode)
            1: begin
               in_valid = t_iv; in_data = t_d; in_last = t_l;
            end
            2: begin
               if (!in_valid && src_d.size() != 0 && $urandom_range(99) < p_rate) begin
                  in_valid = 1'b1; in_data = src_d[0]; in_last = src_l[0];
               end
            end
            default: in_valid = 1'b0;
         endcase
         take = in_valid && in_ready && (pmode == 2);
         @(posedge clk); #1;
         if (take) begin
            void'(src_d.pop_front());
            void'(src_l.pop_front());
            n_acc++;
            in_valid = 1'b0;
         end
      end
   end

   initial begin : consumer
      logic         hs, stall, ee;
      logic [7:0]   ysave [0:63];
      logic [511:0] ey;
      int           bad, bb;
      forever begin
         @(negedge clk);
         out_ready = (cmode == 2) ? ($urandom_range(99) < c_rate) : man_ready;
         hs    = (cmode != 0) && out_valid && out_ready;
         stall = (cmode != 0) && out_valid && !out_ready;
         if (hs) begin
            n_vec++;
            if (exp_y.size() == 0) begin
               n_err++;
               $display("FAIL block: unexpected block released, got y[0]=%h, want no block", y[0]);
            end else begin
               ey = exp_y.pop_front();
               ee = exp_e.pop_front();
               bad = -1;
               for (int i = 0; i < 64; i++) if (y[i] !== ey[i*8 +: 8] && bad < 0) bad = i;
               bb = (bad < 0) ? 0 : bad;
               if (bad >= 0 || out_err !== ee) begin
                  n_err++;
                  $display("FAIL block %0d: y[%0d]=%h want %h, out_err=%b want %b",
                           n_blk, bb, y[bb], ey[bb*8 +: 8], out_err, ee);
               end
            end
            n_blk++;
         end
         if (stall) for (int i = 0; i < 64; i++) ysave[i] = y[i];
         @(posedge clk); #1;
         if (stall) begin
            bad = -1;
            for (int i = 0; i < 64; i++) if (y[i] !== ysave[i] && bad < 0) bad = i;
            bb = (bad < 0) ? 0 : bad;
            n_vec++;
            if (bad >= 0 || out_valid !== 1'b1) begin
               n_err++;
               $display("FAIL stall hold: y[%0d]=%h want %h, out_valid=%b want 1",
                        bb, y[bb], ysave[bb], out_valid);
            end
         end
      end
   end

   initial begin : main
      int base, t0, t1, c, blk0, len;
      logic ok;

      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst in_ready", -1, 8'(in_ready), 8'h01);
      chk("rst out_valid", -1, 8'(out_valid), 8'h00);
      chk("rst out_err", -1, 8'(out_err), 8'h00);
      ok = 1'b1;
      for (int i = 0; i < 64; i++) if (y[i] !== 8'h00) ok = 1'b0;
      chk("rst y zero", -1, 8'(ok), 8'h01);

      // Directed table: short framed block, release, single-sample block, idle ready.
      for (int i = 0; i < 10; i++)
         tbl[i] = mk(1'b1, 8'hAA, i == 9, 1'b0, 1'b1, i == 9, i == 9, 6'(i), 8'hAA);
      tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd10, 8'h00);
      tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  8'h00);
      tbl[12] = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  8'h11);
      tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00);
      tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00);
      tbl[15] = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0,  8'h22);
      tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00);
      pmode = 1;
      for (int r = 0; r < 17; r++) begin
         t_iv = tbl[r].iv; t_d = tbl[r].d; t_l = tbl[r].l; man_ready = tbl[r].ordy;
         @(posedge clk); #1;
         chk("tbl in_ready", r, 8'(in_ready), 8'(tbl[r].e_rdy));
         chk("tbl out_valid", r, 8'(out_valid), 8'(tbl[r].e_ov));
         chk("tbl out_err", r, 8'(out_err), 8'(tbl[r].e_err));
         chk("tbl y", r, y[tbl[r].yi], tbl[r].yv);
      end
      t_iv = 1'b0;
      man_ready = 1'b0;
      @(posedge clk); #1;

      // Ramp block 0x00..0x3F with consumer always ready.
      pmode = 2; p_rate = 100; cmode = 2; c_rate = 100;
      base = n_acc; t0 = 0; t1 = 0; c = 0;
      for (int i = 0; i < 64; i++) mpush(8'(i), i == 63);
      while (n_acc < base + 64 && c < 400) begin
         @(posedge clk); #2;
         c++;
         if (n_acc == base + 1) t0 = cyc;
         if (n_acc == base + 64) t1 = cyc;
      end
      chk("ramp accepted", -1, 8'(n_acc - base), 8'd64);
      chk("ramp out_valid", -1, 8'(out_valid), 8'h01);
      chk("ramp out_err", -1, 8'(out_err), 8'h00);
      ok = 1'b1;
      for (int i = 0; i < 64; i++) if (y[i] !== 8'(i)) ok = 1'b0;
      chk("ramp y[i]=i", -1, 8'(ok), 8'h01);
      chk("ramp back-to-back cycles", -1, 8'(t1 - t0), 8'd63);
      @(posedge clk); #2;
      chk("ramp out_valid pulse", -1, 8'(out_valid), 8'h00);
      drain("ramp", 200);

      // 64 unframed samples, then a properly framed block.
      for (int i = 0; i < 64; i++) mpush(8'(i) ^ 8'hC3, 1'b0);
      for (int i = 0; i < 64; i++) mpush(8'(i) ^ 8'h3C, i == 63);
      drain("unframed", 1000);

      // Three blocks with the consumer stalled: both banks fill, then release one.
      cmode = 1; man_ready = 1'b0;
      base = n_acc; c = 0;
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 64; i++) mpush(8'((b << 6) | i) ^ 8'h5A, i == 63);
      @(posedge clk); #2;
      while (in_ready && c < 400) begin
         @(posedge clk); #2;
         c++;
      end
      chk("full accepted", -1, 8'(n_acc - base), 8'd128);
      repeat (3) @(posedge clk);
      #2;
      chk("full in_ready", -1, 8'(in_ready), 8'h00);
      chk("full out_valid", -1, 8'(out_valid), 8'h01);
      man_ready = 1'b1;
      @(posedge clk); #2;
      man_ready = 1'b0;
      chk("release in_ready", -1, 8'(in_ready), 8'h01);
      chk("release out_valid", -1, 8'(out_valid), 8'h01);
      cmode = 2; c_rate = 100;
      drain("full", 1000);

      // Reset in the middle of a block discards it.
      for (int i = 0; i < 30; i++) begin
         src_d.push_back(8'h77);
         src_l.push_back(1'b0);
      end
      c = 0;
      while ((src_d.size() != 0 || in_valid) && c < 200) begin
         @(posedge clk); #2;
         c++;
      end
      chk("partial accepted", -1, 8'(src_d.size()), 8'd0);
      rst = 1'b0;
      #1;
      chk("midrst out_valid", -1, 8'(out_valid), 8'h00);
      chk("midrst in_ready", -1, 8'(in_ready), 8'h01);
      ok = 1'b1;
      for (int i = 0; i < 64; i++) if (y[i] !== 8'h00) ok = 1'b0;
      chk("midrst y zero", -1, 8'(ok), 8'h01);
      @(posedge clk); #1;
      rst = 1'b1;
      blk0 = n_blk;
      for (int i = 0; i < 64; i++) mpush(8'h55, i == 63);
      drain("after reset", 400);
      chk("after reset blocks", -1, 8'(n_blk - blk0), 8'd1);

      // Random stalls on both sides over 100 blocks.
      p_rate = 70; c_rate = 40;
      for (int b = 0; b < 100; b++) begin
         len = (b % 7 == 3) ? int'($urandom_range(63, 1)) : 64;
         for (int i = 0; i < len; i++)
            mpush(8'($urandom_range(255)), (b % 11 != 5) && (i == len - 1));
      end
      drain("random", 60000);
      chk("total blocks", -1, 8'(n_blk), 8'(m_blocks));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
